gpio_fun_ctrl: RTL and testbench
================================

GPIO_FUN_CTRL -- requirements
Module: gpio_fun_ctrl

Interface
REQ-001 SHALL have parameter NPIN, default 8: number of managed GPIO pins (2..16).
REQ-002 SHALL have parameter GUARD, default 2: break-before-make hold cycles (1..15).
REQ-003 SHALL have port clk  input  1: single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1: synchronous, active-high reset.
REQ-005 SHALL have port cpu_req  input  1: CPU function-change request; held until cpu_ack.
REQ-006 SHALL have port cpu_pin  input  $clog2(NPIN): CPU target pin index.
REQ-007 SHALL have port cpu_fun  input  2: CPU requested function (0 input, 1 output, 2 uart_TX, 3 off).
REQ-008 SHALL have port cpu_ack  output  1: one-cycle completion pulse to CPU.
REQ-009 SHALL have ports tmr_req, tmr_pin, tmr_fun, tmr_ack: timer requester, same widths/rules as the CPU ports.
REQ-010 SHALL have port fun_out  output  2*NPIN: per-pin fun select; pin k uses bits [2k+1:2k].
REQ-011 SHALL have port busy  output  1: high whenever FSM is not IDLE.
REQ-012 SHALL have port err  output  1: one-cycle pulse coincident with a rejecting ack.

Function
REQ-013 SHALL implement FSM states IDLE, CHECK, BREAK, MAKE.
REQ-014 IDLE: if any req is high, SHALL grant one requester, latch its pin/fun, go to CHECK next cycle.
REQ-015 Arbitration SHALL be round-robin: on simultaneous requests, grant the requester not granted last; after reset the CPU wins first.
REQ-016 Requester's pin/fun SHALL be sampled only in the grant cycle; later input changes SHALL not affect the operation.
REQ-017 CHECK, latched pin index >= NPIN: SHALL pulse ack+err, return to IDLE, fun_out unchanged.
REQ-018 CHECK, fun=2 while a different pin already holds 2: SHALL pulse ack+err, return to IDLE (at most one uart_TX pin).
REQ-019 CHECK, fun equal to the pin's current fun: SHALL pulse ack (no err), return to IDLE, no BREAK.
REQ-020 CHECK otherwise: SHALL set the target pin's fun_out to 3 (all buffers off), enter BREAK, load guard counter with GUARD.
REQ-021 BREAK: SHALL hold fun 3 for exactly GUARD cycles, decrementing the counter, then enter MAKE.
REQ-022 MAKE: SHALL write latched fun to the target pin, pulse the granted ack, return to IDLE.
REQ-023 Latency from grant to ack for a real change SHALL be GUARD+3 cycles; no-op or reject SHALL be 2 cycles.
REQ-024 Only the target pin's fun_out field SHALL ever change during an operation.
REQ-025 A requester deasserting req mid-operation SHALL not abort it; ack still pulses.
REQ-026 A requester SHALL not be re-granted in the cycle its ack pulses (IDLE re-entry required first).
REQ-027 fun_out SHALL be registered; no combinational path from req inputs to fun_out.

Reset
REQ-028 rst SHALL force FSM to IDLE, every fun_out field to 0 (input), cpu_ack/tmr_ack/err/busy to 0, guard counter to 0, round-robin pointer to CPU.
REQ-029 rst asserted during BREAK or MAKE SHALL abandon the operation with no ack; reset values take effect next edge.

Structure
REQ-030 Shared package SHALL hold function encodings FUN_IN=0, FUN_OUT=1, FUN_TX=2, FUN_OFF=3 and FSM state typedef.
REQ-031 Round-robin two-requester arbiter SHALL be a sub-module named gpio_rr_arb2 (req[1:0] in, grant[1:0] one-hot out, advance strobe in).
REQ-032 Existing per-pin buffer mux cells SHALL consume fun_out fields unchanged; this block SHALL not drive pins directly.

Verification
REQ-033 Reset: after rst, fun_out == 0, busy 0, no acks.
REQ-034 CPU pin 3 fun 1, GUARD=2: fun_out[7:6] 0 -> 3 for 2 cycles -> 1; cpu_ack at grant+5; err 0.
REQ-035 Pin 1 set to 2, then CPU pin 4 fun 2 -> cpu_ack+err after 2 cycles; fun_out[9:8] stays 0.
REQ-036 CPU and timer request same cycle (pin 0 fun 1, pin 2 fun 1) -> CPU served first, timer next; second time simultaneous, timer first.
REQ-037 Request pin 5 fun 0 while already 0 -> ack at grant+2, no fun 3 glitch on fun_out[11:10].
REQ-038 rst pulsed in BREAK of pin 6 change -> no ack; fun_out all 0 next cycle.

Source files
------------

// File: rtl/gpio_fun_ctrl_pkg.sv
// Shared encodings and types for the GPIO function-select controller.
// Function codes match the per-pin buffer mux cells.
package gpio_fun_ctrl_pkg;

  localparam logic [1:0] FUN_IN  = 2'd0;
  localparam logic [1:0] FUN_OUT = 2'd1;
  localparam logic [1:0] FUN_TX  = 2'd2;
  localparam logic [1:0] FUN_OFF = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_BREAK = 2'd2,
    ST_MAKE  = 2'd3
  } fsm_state_t;

  // Two-way round-robin pick; bit 0 is the CPU, bit 1 the timer.
  function automatic logic [1:0] rr_grant(input logic [1:0] req, input logic prio_tmr);
    logic [1:0] g;
    case (req)
      2'b01:   g = 2'b01;
      2'b10:   g = 2'b10;
      2'b11:   g = prio_tmr ? 2'b10 : 2'b01;
      default: g = 2'b00;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/gpio_fun_ctrl_arb.sv
// Two-requester round-robin arbiter: the requester not granted last wins a tie.
// The priority pointer only moves when the owner strobes advance.
module gpio_rr_arb2
  import gpio_fun_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic       prio_tmr_r;
  logic [1:0] grant_s;

  // Combinational one-hot grant from current requests and pointer
  always_comb begin
    grant_s = rr_grant(req, prio_tmr_r);
  end

  assign grant = grant_s;

  // Pointer update: after a grant, the other requester gets priority
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_tmr_r <= 1'b0;
    end else if (advance && (grant_s != 2'b00)) begin
      prio_tmr_r <= grant_s[0];
    end else begin
      prio_tmr_r <= prio_tmr_r;
    end
  end

endmodule

// File: rtl/gpio_fun_ctrl.sv
// Serialises CPU/timer pin-function changes with a break-before-make hold,
// guaranteeing at most one uart_TX pin and registered fun_out fields.
module gpio_fun_ctrl
  import gpio_fun_ctrl_pkg::*;
#(
  parameter int NPIN  = 8,
  parameter int GUARD = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cpu_req,
  input  logic [$clog2(NPIN)-1:0] cpu_pin,
  input  logic [1:0]              cpu_fun,
  output logic                    cpu_ack,
  input  logic                    tmr_req,
  input  logic [$clog2(NPIN)-1:0] tmr_pin,
  input  logic [1:0]              tmr_fun,
  output logic                    tmr_ack,
  output logic [2*NPIN-1:0]       fun_out,
  output logic                    busy,
  output logic                    err
);

  localparam int PW = $clog2(NPIN);

  fsm_state_t        state_r;
  logic [PW-1:0]     pin_r;
  logic [1:0]        fun_r;
  logic              grant_tmr_r;
  logic [3:0]        cnt_r;
  logic [2*NPIN-1:0] fun_out_r;
  logic              cpu_ack_r;
  logic              tmr_ack_r;
  logic              err_r;
  logic              busy_r;

  logic [1:0]        req_s;
  logic [1:0]        grant_s;
  logic              advance_s;
  logic              pin_ok_s;
  logic              tx_conflict_s;
  logic [1:0]        cur_fun_s;
  logic [2*NPIN-1:0] off_vec_s;
  logic [2*NPIN-1:0] make_vec_s;

  // A requester whose ack is pulsing must see IDLE once before it can win again
  always_comb begin
    req_s     = {tmr_req & ~tmr_ack_r, cpu_req & ~cpu_ack_r};
    advance_s = (state_r == ST_IDLE) && (req_s != 2'b00);
  end

  gpio_rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_s),
    .advance (advance_s),
    .grant   (grant_s)
  );

  // Target-pin lookups and the two candidate fun_out images (buffers off / final)
  always_comb begin
    pin_ok_s      = (int'(pin_r) < NPIN);
    tx_conflict_s = 1'b0;
    cur_fun_s     = FUN_IN;
    off_vec_s     = fun_out_r;
    make_vec_s    = fun_out_r;
    for (int k = 0; k < NPIN; k++) begin
      if (int'(pin_r) == k) begin
        cur_fun_s            = fun_out_r[2*k +: 2];
        off_vec_s[2*k +: 2]  = FUN_OFF;
        make_vec_s[2*k +: 2] = fun_r;
      end else begin
        tx_conflict_s = tx_conflict_s | (fun_out_r[2*k +: 2] == FUN_TX);
      end
    end
  end

  // Main sequencer; all outputs are registered here
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      pin_r       <= '0;
      fun_r       <= FUN_IN;
      grant_tmr_r <= 1'b0;
      cnt_r       <= 4'd0;
      fun_out_r   <= '0;
      cpu_ack_r   <= 1'b0;
      tmr_ack_r   <= 1'b0;
      err_r       <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      cpu_ack_r <= 1'b0;
      tmr_ack_r <= 1'b0;
      err_r     <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (advance_s) begin
            grant_tmr_r <= grant_s[1];
            pin_r       <= grant_s[1] ? tmr_pin : cpu_pin;
            fun_r       <= grant_s[1] ? tmr_fun : cpu_fun;
            state_r     <= ST_CHECK;
            busy_r      <= 1'b1;
          end else begin
            busy_r      <= 1'b0;
          end
        end
        ST_CHECK: begin
          if (!pin_ok_s || ((fun_r == FUN_TX) && tx_conflict_s)) begin
            cpu_ack_r <= ~grant_tmr_r;
            tmr_ack_r <= grant_tmr_r;
            err_r     <= 1'b1;
            state_r   <= ST_IDLE;
            busy_r    <= 1'b0;
          end else if (fun_r == cur_fun_s) begin
            cpu_ack_r <= ~grant_tmr_r;
            tmr_ack_r <= grant_tmr_r;
            state_r   <= ST_IDLE;
            busy_r    <= 1'b0;
          end else begin
            fun_out_r <= off_vec_s;
            cnt_r     <= 4'(GUARD);
            state_r   <= ST_BREAK;
          end
        end
        ST_BREAK: begin
          // New function lands on the edge ending the last hold cycle
          if (cnt_r <= 4'd1) begin
            fun_out_r <= make_vec_s;
            cnt_r     <= 4'd0;
            state_r   <= ST_MAKE;
          end else begin
            cnt_r     <= cnt_r - 4'd1;
          end
        end
        ST_MAKE: begin
          fun_out_r <= make_vec_s;
          cpu_ack_r <= ~grant_tmr_r;
          tmr_ack_r <= grant_tmr_r;
          state_r   <= ST_IDLE;
          busy_r    <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign fun_out = fun_out_r;
  assign cpu_ack = cpu_ack_r;
  assign tmr_ack = tmr_ack_r;
  assign err     = err_r;
  assign busy    = busy_r;

endmodule

// File: tb/tb_gpio_fun_ctrl.sv
// Directed bench for gpio_fun_ctrl (NPIN=8, GUARD=2); outputs sampled 1ns after each rising edge.
module tb_gpio_fun_ctrl;

  logic        clk;
  logic        rst;
  logic        cpu_req;
  logic [2:0]  cpu_pin;
  logic [1:0]  cpu_fun;
  logic        cpu_ack;
  logic        tmr_req;
  logic [2:0]  tmr_pin;
  logic [1:0]  tmr_fun;
  logic        tmr_ack;
  logic [15:0] fun_out;
  logic        busy;
  logic        err;

  int n_checks;
  int n_fail;

  gpio_fun_ctrl #(.NPIN(8), .GUARD(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .cpu_req (cpu_req),
    .cpu_pin (cpu_pin),
    .cpu_fun (cpu_fun),
    .cpu_ack (cpu_ack),
    .tmr_req (tmr_req),
    .tmr_pin (tmr_pin),
    .tmr_fun (tmr_fun),
    .tmr_ack (tmr_ack),
    .fun_out (fun_out),
    .busy    (busy),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++; if (fun_out !== 16'h0000) begin n_fail++; $display("FAIL reset_fun_out: got %h expected %h", fun_out, 16'h0000); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if ({cpu_ack, tmr_ack} !== 2'b00) begin n_fail++; $display("FAIL reset_acks: got %b expected 00", {cpu_ack, tmr_ack}); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
    rst = 1'b0;
  endtask

  // CPU pin 3 -> output; inputs scrambled after grant must not matter
  task automatic test_change();
    logic [1:0]  ef;
    logic [15:0] ev;
    cpu_pin = 3'd3; cpu_fun = 2'd1; cpu_req = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      tick();
      ef = (n == 1) ? 2'd0 : ((n <= 3) ? 2'd3 : 2'd1);
      ev = 16'(ef) << 6;
      n_checks++; if (fun_out !== ev) begin n_fail++; $display("FAIL change_fun_out n=%0d: got %h expected %h", n, fun_out, ev); end
      n_checks++; if (cpu_ack !== (n == 5)) begin n_fail++; $display("FAIL change_cpu_ack n=%0d: got %b expected %b", n, cpu_ack, (n == 5)); end
      n_checks++; if (busy !== (n <= 4)) begin n_fail++; $display("FAIL change_busy n=%0d: got %b expected %b", n, busy, (n <= 4)); end
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL change_err n=%0d: got %b expected 0", n, err); end
      if (n == 1) begin cpu_pin = 3'd0; cpu_fun = 2'd2; end
      if (n == 5) cpu_req = 1'b0;
    end
    tick();
  endtask

  // Timer no-op on pin 5, req held one cycle past ack: no glitch, no re-grant
  task automatic test_noop_regrant();
    tmr_pin = 3'd5; tmr_fun = 2'd0; tmr_req = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      tick();
      n_checks++; if (fun_out !== 16'h0040) begin n_fail++; $display("FAIL noop_fun_out n=%0d: got %h expected %h", n, fun_out, 16'h0040); end
      n_checks++; if (tmr_ack !== (n == 2)) begin n_fail++; $display("FAIL noop_tmr_ack n=%0d: got %b expected %b", n, tmr_ack, (n == 2)); end
      n_checks++; if (cpu_ack !== 1'b0) begin n_fail++; $display("FAIL noop_cpu_ack n=%0d: got %b expected 0", n, cpu_ack); end
      n_checks++; if (busy !== (n == 1)) begin n_fail++; $display("FAIL noop_busy n=%0d: got %b expected %b", n, busy, (n == 1)); end
      if (n == 3) tmr_req = 1'b0;
    end
  endtask

  // Pin 1 to TX, then a second TX pin is refused with err
  task automatic test_tx_reject();
    cpu_pin = 3'd1; cpu_fun = 2'd2; cpu_req = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      tick();
      if (n == 5) begin
        n_checks++; if (cpu_ack !== 1'b1) begin n_fail++; $display("FAIL tx_set_ack: got %b expected 1", cpu_ack); end
        n_checks++; if (fun_out !== 16'h0048) begin n_fail++; $display("FAIL tx_set_fun_out: got %h expected %h", fun_out, 16'h0048); end
      end
    end
    cpu_req = 1'b0;
    tick();
    cpu_pin = 3'd4; cpu_fun = 2'd2; cpu_req = 1'b1;
    for (int n = 1; n <= 3; n++) begin
      tick();
      n_checks++; if (fun_out !== 16'h0048) begin n_fail++; $display("FAIL tx_rej_fun_out n=%0d: got %h expected %h", n, fun_out, 16'h0048); end
      n_checks++; if (cpu_ack !== (n == 2)) begin n_fail++; $display("FAIL tx_rej_ack n=%0d: got %b expected %b", n, cpu_ack, (n == 2)); end
      n_checks++; if (err !== (n == 2)) begin n_fail++; $display("FAIL tx_rej_err n=%0d: got %b expected %b", n, err, (n == 2)); end
      if (n == 2) cpu_req = 1'b0;
    end
  endtask

  // Simultaneous requests: CPU first after reset; timer first once CPU was last served
  task automatic test_round_robin();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    cpu_pin = 3'd0; cpu_fun = 2'd1; cpu_req = 1'b1;
    tmr_pin = 3'd2; tmr_fun = 2'd1; tmr_req = 1'b1;
    for (int n = 1; n <= 11; n++) begin
      tick();
      n_checks++; if (cpu_ack !== (n == 5)) begin n_fail++; $display("FAIL rr1_cpu_ack n=%0d: got %b expected %b", n, cpu_ack, (n == 5)); end
      n_checks++; if (tmr_ack !== (n == 10)) begin n_fail++; $display("FAIL rr1_tmr_ack n=%0d: got %b expected %b", n, tmr_ack, (n == 10)); end
      n_checks++; if (busy !== ((n <= 4) || (n >= 6 && n <= 9))) begin n_fail++; $display("FAIL rr1_busy n=%0d: got %b", n, busy); end
      if (n == 5) cpu_req = 1'b0;
      if (n == 10) tmr_req = 1'b0;
    end
    n_checks++; if (fun_out !== 16'h0011) begin n_fail++; $display("FAIL rr1_fun_out: got %h expected %h", fun_out, 16'h0011); end
    cpu_pin = 3'd0; cpu_fun = 2'd1; cpu_req = 1'b1;
    tick(); tick();
    n_checks++; if (cpu_ack !== 1'b1) begin n_fail++; $display("FAIL rr_cpu_noop_ack: got %b expected 1", cpu_ack); end
    cpu_req = 1'b0;
    tick();
    cpu_pin = 3'd0; cpu_fun = 2'd0; cpu_req = 1'b1;
    tmr_pin = 3'd2; tmr_fun = 2'd0; tmr_req = 1'b1;
    for (int n = 1; n <= 11; n++) begin
      tick();
      n_checks++; if (tmr_ack !== (n == 5)) begin n_fail++; $display("FAIL rr2_tmr_ack n=%0d: got %b expected %b", n, tmr_ack, (n == 5)); end
      n_checks++; if (cpu_ack !== (n == 10)) begin n_fail++; $display("FAIL rr2_cpu_ack n=%0d: got %b expected %b", n, cpu_ack, (n == 10)); end
      if (n == 5) begin
        n_checks++; if (fun_out !== 16'h0001) begin n_fail++; $display("FAIL rr2_mid_fun_out: got %h expected %h", fun_out, 16'h0001); end
        tmr_req = 1'b0;
      end
      if (n == 10) cpu_req = 1'b0;
    end
    n_checks++; if (fun_out !== 16'h0000) begin n_fail++; $display("FAIL rr2_fun_out: got %h expected %h", fun_out, 16'h0000); end
  endtask

  // Reset during BREAK of a pin 6 change abandons it silently
  task automatic test_reset_in_break();
    cpu_pin = 3'd6; cpu_fun = 2'd1; cpu_req = 1'b1;
    tick(); tick();
    n_checks++; if (fun_out !== 16'h3000) begin n_fail++; $display("FAIL rib_break_fun_out: got %h expected %h", fun_out, 16'h3000); end
    rst = 1'b1; cpu_req = 1'b0;
    tick();
    rst = 1'b0;
    n_checks++; if (fun_out !== 16'h0000) begin n_fail++; $display("FAIL rib_fun_out: got %h expected %h", fun_out, 16'h0000); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rib_busy: got %b expected 0", busy); end
    for (int n = 1; n <= 6; n++) begin
      tick();
      n_checks++; if ({cpu_ack, tmr_ack, err} !== 3'b000) begin n_fail++; $display("FAIL rib_no_ack n=%0d: got %b expected 000", n, {cpu_ack, tmr_ack, err}); end
      n_checks++; if (fun_out !== 16'h0000) begin n_fail++; $display("FAIL rib_hold n=%0d: got %h expected %h", n, fun_out, 16'h0000); end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    cpu_req = 1'b0; cpu_pin = 3'd0; cpu_fun = 2'd0;
    tmr_req = 1'b0; tmr_pin = 3'd0; tmr_fun = 2'd0;
    test_reset();
    test_change();
    test_noop_regrant();
    test_tx_reject();
    test_round_robin();
    test_reset_in_break();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
